sdram_arbiter: RTL

Two-port arbiter that shares the single SDRAM controller command port between the video scanout fetcher (read-only, latency-critical) and the CPU bus (read/write). It sits in `top` between those two requesters and the SDRAM controller, all in the `clk_sys` domain. Video has fixed priority, with a starvation guard that guarantees the CPU a slot. An in-order tag FIFO routes returned read data back to the requester that issued the read.

---
 rtl/sdram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - video/CPU arbiter for the shared SDRAM controller command port
module sdram_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int MAX_VID_RUN = 8,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                clk_sys,
    input  logic                rst_n,

    input  logic                vid_req_i,
    input  logic [ADDR_W-1:0]   vid_addr_i,
    output logic                vid_ready_o,
    output logic [DATA_W-1:0]   vid_rdata_o,
    output logic                vid_rvalid_o,

    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_wstrb_i,
    output logic                cpu_ready_o,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_rvalid_o,

    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_rvalid_i,

    output logic                err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int RUN_W  = $clog2(MAX_VID_RUN + 1);

    localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_VID_RUN);

    logic             tag_id [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_count;
    logic [RUN_W-1:0] run_cnt;

    logic stage_free;
    logic read_ok;
    logic vid_elig;
    logic cpu_elig;
    logic grant_vid;
    logic grant_cpu;
    logic push;
    logic pop;
    logic head_id;

    assign stage_free = !mem_valid_o || mem_ready_i;
    // A same-cycle pop does not free a slot: eligibility uses the registered count only.
    assign read_ok    = (tag_count < TAG_FULL);
    assign vid_elig   = vid_req_i && read_ok;
    assign cpu_elig   = cpu_req_i && (cpu_we_i || read_ok);

    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (stage_free) begin
            if (vid_elig && !(cpu_elig && (run_cnt == RUN_MAX))) begin
                grant_vid = 1'b1;
            end else if (cpu_elig) begin
                grant_cpu = 1'b1;
            end
        end
    end

    assign vid_ready_o = grant_vid;
    assign cpu_ready_o = grant_cpu;

    assign push    = grant_vid || (grant_cpu && !cpu_we_i);
    assign pop     = mem_rvalid_i && (tag_count != '0);
    assign head_id = tag_id[rd_ptr];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else if (grant_vid) begin
            mem_valid_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= vid_addr_i;
            mem_wdata_o <= '0;
            mem_wstrb_o <= {STRB_W{1'b1}};
        end else if (grant_cpu) begin
            mem_valid_o <= 1'b1;
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
            mem_wstrb_o <= cpu_wstrb_i;
        end else if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!cpu_req_i || grant_cpu) begin
            run_cnt <= '0;
        end else if (grant_vid && (run_cnt != RUN_MAX)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Tag FIFO: records which requester owns each outstanding read, in issue order.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_id[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                tag_id[wr_ptr] <= grant_cpu;
                wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vid_rdata_o  <= '0;
            vid_rvalid_o <= 1'b0;
            cpu_rdata_o  <= '0;
            cpu_rvalid_o <= 1'b0;
        end else begin
            vid_rvalid_o <= pop && !head_id;
            cpu_rvalid_o <= pop && head_id;
            if (pop && !head_id) begin
                vid_rdata_o <= mem_rdata_i;
            end
            if (pop && head_id) begin
                cpu_rdata_o <= mem_rdata_i;
            end
        end
    end

    // A return with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (mem_rvalid_i && (tag_count == '0)) begin
            err_o <= 1'b1;
        end
    end

endmodule
